// File: rtl/flit_checksum_verifier.sv
// Receive-side flit checksum verifier: recomputes the 8-bit wrap-around sum of header+payload
// serially, compares it against the carried checksum, then forwards or drops the flit.
module flit_checksum_verifier #(
  parameter int FLIT_WIDTH      = 64,
  parameter int CHECKSUM_WIDTH  = 8,
  parameter int BYTES_PER_CYCLE = 1,
  parameter bit DROP_ON_ERROR   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_checksum_ok,
  output logic                  err_pulse,
  output logic [15:0]           err_count,
  input  logic                  err_count_clr
);

  localparam int NB    = (FLIT_WIDTH - 8) / 8;
  localparam int IDX_W = $clog2(NB + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  if (CHECKSUM_WIDTH != 8) begin : g_bad_checksum_width
    $error("flit_checksum_verifier: CHECKSUM_WIDTH must be 8");
  end
  if (((FLIT_WIDTH - CHECKSUM_WIDTH) % 8) != 0) begin : g_bad_flit_width
    $error("flit_checksum_verifier: FLIT_WIDTH-CHECKSUM_WIDTH must be a multiple of 8");
  end
  if ((BYTES_PER_CYCLE < 1) || ((NB % BYTES_PER_CYCLE) != 0)) begin : g_bad_bytes_per_cycle
    $error("flit_checksum_verifier: BYTES_PER_CYCLE must divide the header+payload byte count");
  end

  logic [1:0]            state_q, state_d;
  logic [FLIT_WIDTH-1:0] flit_q, flit_d;
  logic [7:0]            acc_q, acc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  ok_q, ok_d;
  logic                  err_pulse_q, err_pulse_d;
  logic [15:0]           err_count_q, err_count_d;

  logic [7:0] acc_next;
  logic [7:0] sum_chk;
  logic       last_step;
  logic       sum_good;
  logic       mismatch;

  // Bytes idx_q .. idx_q+BYTES_PER_CYCLE-1, byte 0 being the MSB byte of the flit.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so each line sees the value just computed;
    // every variable gets a default first so no path can infer a latch.
    acc_next = acc_q;
    for (int b = 0; b < NB; b++) begin
      if ((b >= int'(idx_q)) && (b < int'(idx_q) + BYTES_PER_CYCLE)) begin
        acc_next = acc_next + flit_q[FLIT_WIDTH-1-8*b -: 8];
      end
    end
  end

  assign sum_chk   = acc_next + flit_q[CHECKSUM_WIDTH-1:0];
  assign sum_good  = (sum_chk == 8'hFF);
  assign last_step = (int'(idx_q) + BYTES_PER_CYCLE) >= NB;

  always_comb begin
    state_d     = state_q;
    flit_d      = flit_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    ok_d        = ok_q;
    mismatch    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          flit_d  = in_flit;
          acc_d   = 8'h00;
          idx_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = acc_next;
        idx_d = idx_q + IDX_W'(BYTES_PER_CYCLE);
        if (last_step) begin
          mismatch = !sum_good;
          if (sum_good || !DROP_ON_ERROR) begin
            ok_d    = sum_good;
            state_d = S_HOLD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    err_pulse_d = mismatch;

    // A clear coinciding with a new mismatch keeps that mismatch.
    if (err_count_clr) begin
      err_count_d = mismatch ? 16'd1 : 16'd0;
    end else if (mismatch && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      flit_q      <= '0;
      acc_q       <= 8'h00;
      idx_q       <= '0;
      ok_q        <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= 16'h0000;
    end else begin
      // NOTE: registers update with non-blocking '<=' so every flop samples pre-edge values.
      state_q     <= state_d;
      flit_q      <= flit_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      ok_q        <= ok_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign in_ready        = (state_q == S_IDLE);
  assign out_valid       = (state_q == S_HOLD);
  assign out_flit        = flit_q;
  assign out_checksum_ok = ok_q;
  assign err_pulse       = err_pulse_q;
  assign err_count       = err_count_q;

endmodule

// File: tb/tb_flit_checksum_verifier.sv
// Directed self-checking bench for flit_checksum_verifier: one forwarding instance and one
// drop-on-error instance sharing clock and reset.
module tb_flit_checksum_verifier;

  localparam logic [63:0] G1     = 64'h01020304050607E3; // sum 1C, chk E3
  localparam logic [63:0] G2     = 64'hFFFFFFFFFFFFFF06; // sum F9, chk 06
  localparam logic [63:0] G3     = 64'h1122334455667723; // sum DC, chk 23
  localparam logic [63:0] Z_OK   = 64'h00000000000000FF;
  localparam logic [63:0] Z_BAD  = 64'h0000000000000000;
  localparam logic [63:0] B1     = 64'h0102030405060700; // sum 1C, chk 00

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] in_flit;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_flit;
  logic        out_valid;
  logic        out_ready;
  logic        out_checksum_ok;
  logic        err_pulse;
  logic [15:0] err_count;
  logic        err_count_clr;

  logic        d_in_valid;
  logic        d_in_ready;
  logic [63:0] d_out_flit;
  logic        d_out_valid;
  logic        d_out_checksum_ok;
  logic        d_err_pulse;
  logic [15:0] d_err_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  flit_checksum_verifier #(
    .FLIT_WIDTH(64), .CHECKSUM_WIDTH(8), .BYTES_PER_CYCLE(1), .DROP_ON_ERROR(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
    .out_checksum_ok(out_checksum_ok), .err_pulse(err_pulse),
    .err_count(err_count), .err_count_clr(err_count_clr)
  );

  flit_checksum_verifier #(
    .FLIT_WIDTH(64), .CHECKSUM_WIDTH(8), .BYTES_PER_CYCLE(1), .DROP_ON_ERROR(1'b1)
  ) dut_drop (
    .clk(clk), .rst_n(rst_n),
    .in_flit(in_flit), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .out_flit(d_out_flit), .out_valid(d_out_valid), .out_ready(out_ready),
    .out_checksum_ok(d_out_checksum_ok), .err_pulse(d_err_pulse),
    .err_count(d_err_count), .err_count_clr(err_count_clr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offer f to the forwarding instance; returns at the falling edge after handshake edge E0.
  task automatic start(input logic [63:0] f);
    @(negedge clk);
    check("in_ready_before_send", in_ready, 1'b1);
    in_flit  = f;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Result must appear exactly after edge E0+7, not after E0+6.
  task automatic wait_result(input string tag, input logic [63:0] f, input logic exp_ok);
    repeat (6) @(negedge clk);
    check({tag, "_valid_early"}, out_valid, 1'b0);
    check({tag, "_busy"}, in_ready, 1'b0);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_flit"}, out_flit, f);
    check({tag, "_ok"}, out_checksum_ok, exp_ok);
    check({tag, "_err_pulse"}, err_pulse, !exp_ok);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 1'b0);
    check({tag, "_ready_back"}, in_ready, 1'b1);
    check({tag, "_pulse_gone"}, err_pulse, 1'b0);
  endtask

  initial begin
    rst_n         = 1'b1;
    in_flit       = '0;
    in_valid      = 1'b0;
    d_in_valid    = 1'b0;
    out_ready     = 1'b0;
    err_count_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_flit", out_flit, 64'h0);
    check("rst_ok", out_checksum_ok, 1'b0);
    check("rst_err_pulse", err_pulse, 1'b0);
    check("rst_err_count", err_count, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic good flit, then all-zero payload with good and bad checksums.
    start(G1);
    wait_result("g1", G1, 1'b1);
    check("g1_err_count", err_count, 16'd0);
    consume("g1");

    start(Z_OK);
    wait_result("zok", Z_OK, 1'b1);
    consume("zok");

    start(Z_BAD);
    wait_result("zbad", Z_BAD, 1'b0);
    check("zbad_err_count", err_count, 16'd1);
    @(negedge clk);
    check("zbad_pulse_one_cycle", err_pulse, 1'b0);
    check("zbad_still_valid", out_valid, 1'b1);
    consume("zbad");

    // Drop-on-error instance: bad flit vanishes, good flit is forwarded.
    @(negedge clk);
    check("drop_ready", d_in_ready, 1'b1);
    in_flit    = B1;
    d_in_valid = 1'b1;
    @(negedge clk);
    d_in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("drop_busy", d_in_ready, 1'b0);
    @(negedge clk);
    check("drop_no_valid", d_out_valid, 1'b0);
    check("drop_err_pulse", d_err_pulse, 1'b1);
    check("drop_err_count", d_err_count, 16'd1);
    check("drop_ready_back", d_in_ready, 1'b1);
    @(negedge clk);
    check("drop_pulse_gone", d_err_pulse, 1'b0);
    check("drop_still_no_valid", d_out_valid, 1'b0);

    in_flit    = G1;
    d_in_valid = 1'b1;
    @(negedge clk);
    d_in_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("drop_good_valid", d_out_valid, 1'b1);
    check("drop_good_flit", d_out_flit, G1);
    check("drop_good_ok", d_out_checksum_ok, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drop_good_done", d_out_valid, 1'b0);

    // Backpressure with a second flit offered during HOLD.
    start(G2);
    wait_result("bp", G2, 1'b1);
    in_flit  = G3;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_flit", out_flit, G2);
      check("bp_hold_ok", out_checksum_ok, 1'b1);
      check("bp_hold_not_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_released", out_valid, 1'b0);
    check("bp_ready_after_release", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_second_accepted", in_ready, 1'b0);
    wait_result("bp2", G3, 1'b1);
    consume("bp2");

    // Counter: clear, three mismatches, then clear coinciding with an increment.
    @(negedge clk);
    err_count_clr = 1'b1;
    @(negedge clk);
    err_count_clr = 1'b0;
    check("cnt_cleared", err_count, 16'd0);
    for (int i = 0; i < 3; i++) begin
      start(B1);
      wait_result("cnt_bad", B1, 1'b0);
      consume("cnt_bad");
    end
    check("cnt_three", err_count, 16'd3);

    start(B1);
    repeat (6) @(negedge clk);
    check("cnt_before_clr", err_count, 16'd3);
    err_count_clr = 1'b1;
    @(negedge clk);
    err_count_clr = 1'b0;
    check("cnt_clr_and_inc", err_count, 16'd1);
    check("cnt_clr_pulse", err_pulse, 1'b1);
    check("cnt_clr_valid", out_valid, 1'b1);
    consume("cnt_clr");

    // Saturation at 16'hFFFF.
    @(negedge clk);
    force dut.err_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.err_count_q;
    check("sat_forced", err_count, 16'hFFFF);
    start(B1);
    wait_result("sat", B1, 1'b0);
    check("sat_hold", err_count, 16'hFFFF);
    consume("sat");

    // Asynchronous reset three cycles into CALC with a bad flit in flight.
    start(B1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_flit", out_flit, 64'h0);
    check("mid_rst_ok", out_checksum_ok, 1'b0);
    check("mid_rst_err_pulse", err_pulse, 1'b0);
    check("mid_rst_err_count", err_count, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_no_valid", out_valid, 1'b0);
    check("post_rst_no_count", err_count, 16'h0);
    start(G1);
    wait_result("post_rst", G1, 1'b1);
    check("post_rst_err_count", err_count, 16'd0);
    consume("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
